// File: rtl/shiftregister_circular_left_stepper.sv
// Left-rotating circular shift register with preset load and a start/busy/done stepped rotation.
// Optional macro REVOLUTION_FLAG_EN adds a full-revolution pulse output.
module shiftregister_circular_left_stepper #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned AW    = 4
) (
    input  logic             clockpulse,
    input  logic             clear,
    input  logic             preset_enable,
    input  logic [WIDTH-1:0] preset,
    input  logic             start,
    input  logic [AW-1:0]    amount,
    output logic [WIDTH-1:0] signal_q,
    output logic [WIDTH-1:0] signal_q_,
    output logic             busy,
`ifdef REVOLUTION_FLAG_EN
    output logic             done,
    output logic             revolution
`else
    output logic             done
`endif
);

    typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic [AW-1:0]    remaining_q, remaining_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d     = state_q;
        reg_d       = reg_q;
        remaining_d = remaining_q;
        unique case (state_q)
            IDLE: begin
                if (preset_enable) begin
                    reg_d = preset;
                end else if (start) begin
                    if (amount != AW'(0)) begin
                        state_d     = ROTATE;
                        remaining_d = amount;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ROTATE: begin
                reg_d       = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
                remaining_d = remaining_q - AW'(1);
                if (remaining_q == AW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // busy drops one cycle early so that it covers only the non-final steps
        busy_d = (state_q == ROTATE) && (remaining_q != AW'(1));
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clockpulse) begin
        if (!clear) begin
            state_q     <= IDLE;
            reg_q       <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            reg_q       <= reg_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign signal_q  = reg_q;
    assign signal_q_ = ~reg_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef REVOLUTION_FLAG_EN
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [CW-1:0] step_cnt_q, step_cnt_d;
    logic          revolution_q, revolution_d;
    logic          load_c, step_c;

    // Step counter modulo WIDTH, restarted by every accepted preset load
    always_comb begin
        load_c       = (state_q == IDLE) && preset_enable;
        step_c       = (state_q == ROTATE);
        step_cnt_d   = step_cnt_q;
        revolution_d = 1'b0;
        if (load_c) begin
            step_cnt_d = '0;
        end else if (step_c) begin
            if (step_cnt_q == CW'(WIDTH - 1)) begin
                step_cnt_d   = '0;
                revolution_d = 1'b1;
            end else begin
                step_cnt_d = step_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clockpulse) begin
        if (!clear) begin
            step_cnt_q   <= '0;
            revolution_q <= 1'b0;
        end else begin
            step_cnt_q   <= step_cnt_d;
            revolution_q <= revolution_d;
        end
    end

    assign revolution = revolution_q;
`endif

endmodule

// File: tb/tb_shiftregister_circular_left_stepper.sv
// Directed scoreboard bench for shiftregister_circular_left_stepper (WIDTH=5, AW=4).
module tb_shiftregister_circular_left_stepper;

    logic       clockpulse = 1'b0;
    logic       clear = 1'b0;
    logic       preset_enable = 1'b0;
    logic [4:0] preset = '0;
    logic       start = 1'b0;
    logic [3:0] amount = '0;
    logic [4:0] signal_q;
    logic [4:0] signal_q_;
    logic       busy;
    logic       done;
`ifdef REVOLUTION_FLAG_EN
    logic       revolution;
`endif

    typedef struct {
        string      tag;
        logic [4:0] q;
        logic       busy;
        logic       done;
        logic       rev;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    shiftregister_circular_left_stepper #(.WIDTH(5), .AW(4)) dut (
        .clockpulse   (clockpulse),
        .clear        (clear),
        .preset_enable(preset_enable),
        .preset       (preset),
        .start        (start),
        .amount       (amount),
        .signal_q     (signal_q),
        .signal_q_    (signal_q_),
        .busy         (busy),
`ifdef REVOLUTION_FLAG_EN
        .done         (done),
        .revolution   (revolution)
`else
        .done         (done)
`endif
    );

    always #5 clockpulse = ~clockpulse;

    task automatic step(input string tag, input logic clr, input logic pe,
                        input logic [4:0] pre, input logic st, input logic [3:0] amt,
                        input logic [4:0] eq, input logic eb, input logic ed, input logic er);
        exp_t e;
        exp_t got;
        clear         = clr;
        preset_enable = pe;
        preset        = pre;
        start         = st;
        amount        = amt;
        e.tag = tag; e.q = eq; e.busy = eb; e.done = ed; e.rev = er;
        sb.push_back(e);
        @(posedge clockpulse);
        #1;
        got = sb.pop_front();
        vectors++;
        assert ({signal_q, signal_q_, busy, done} === {got.q, ~got.q, got.busy, got.done})
        else begin
            miscompares++;
            $error("FAIL %s: got q=%b q_=%b busy=%b done=%b, expected q=%b q_=%b busy=%b done=%b",
                   got.tag, signal_q, signal_q_, busy, done, got.q, ~got.q, got.busy, got.done);
        end
`ifdef REVOLUTION_FLAG_EN
        vectors++;
        assert (revolution === got.rev)
        else begin
            miscompares++;
            $error("FAIL %s_rev: got revolution=%b, expected %b", got.tag, revolution, got.rev);
        end
`endif
    endtask

    task automatic idle(input string tag, input logic [4:0] eq, input logic eb,
                        input logic ed, input logic er);
        step(tag, 1'b1, 1'b0, 5'b00000, 1'b0, 4'd0, eq, eb, ed, er);
    endtask

    initial begin
        // reset
        step("reset", 1'b0, 1'b0, 5'b00000, 1'b0, 4'd0, 5'b00000, 0, 0, 0);
        step("load_10110", 1'b1, 1'b1, 5'b10110, 1'b0, 4'd0, 5'b10110, 0, 0, 0);

        // amount=3
        step("load_00001", 1'b1, 1'b1, 5'b00001, 1'b0, 4'd0, 5'b00001, 0, 0, 0);
        step("a3_start", 1'b1, 1'b0, 5'b00000, 1'b1, 4'd3, 5'b00001, 0, 0, 0);
        idle("a3_s1", 5'b00010, 1, 0, 0);
        idle("a3_s2", 5'b00100, 1, 0, 0);
        idle("a3_done", 5'b01000, 0, 1, 0);
        idle("a3_idle", 5'b01000, 0, 0, 0);

        // amount=7 wraps past a full revolution
        step("a7_load", 1'b1, 1'b1, 5'b00001, 1'b0, 4'd0, 5'b00001, 0, 0, 0);
        step("a7_start", 1'b1, 1'b0, 5'b00000, 1'b1, 4'd7, 5'b00001, 0, 0, 0);
        idle("a7_s1", 5'b00010, 1, 0, 0);
        idle("a7_s2", 5'b00100, 1, 0, 0);
        idle("a7_s3", 5'b01000, 1, 0, 0);
        idle("a7_s4", 5'b10000, 1, 0, 0);
        idle("a7_s5", 5'b00001, 1, 0, 1);
        idle("a7_s6", 5'b00010, 1, 0, 0);
        idle("a7_done", 5'b00100, 0, 1, 0);
        idle("a7_idle", 5'b00100, 0, 0, 0);

        // amount=0 goes straight to done
        step("a0_load", 1'b1, 1'b1, 5'b10110, 1'b0, 4'd0, 5'b10110, 0, 0, 0);
        step("a0_start", 1'b1, 1'b0, 5'b00000, 1'b1, 4'd0, 5'b10110, 0, 1, 0);
        idle("a0_idle", 5'b10110, 0, 0, 0);

        // amount=4 with start and preset pulsed while busy
        step("a4_load", 1'b1, 1'b1, 5'b10110, 1'b0, 4'd0, 5'b10110, 0, 0, 0);
        step("a4_start", 1'b1, 1'b0, 5'b00000, 1'b1, 4'd4, 5'b10110, 0, 0, 0);
        idle("a4_s1", 5'b01101, 1, 0, 0);
        step("a4_ign_start", 1'b1, 1'b0, 5'b00000, 1'b1, 4'd2, 5'b11010, 1, 0, 0);
        step("a4_ign_preset", 1'b1, 1'b1, 5'b11111, 1'b0, 4'd0, 5'b10101, 1, 0, 0);
        idle("a4_done", 5'b01011, 0, 1, 0);
        step("done_ign_start", 1'b1, 1'b0, 5'b00000, 1'b1, 4'd3, 5'b01011, 0, 0, 0);
        idle("done_ign_idle", 5'b01011, 0, 0, 0);

        // preset_enable wins over start in the same cycle
        step("prio_both", 1'b1, 1'b1, 5'b00011, 1'b1, 4'd2, 5'b00011, 0, 0, 0);
        idle("prio_idle1", 5'b00011, 0, 0, 0);
        idle("prio_idle2", 5'b00011, 0, 0, 0);

        // clear in the middle of a 9-step rotation
        step("a9_load", 1'b1, 1'b1, 5'b00001, 1'b0, 4'd0, 5'b00001, 0, 0, 0);
        step("a9_start", 1'b1, 1'b0, 5'b00000, 1'b1, 4'd9, 5'b00001, 0, 0, 0);
        idle("a9_s1", 5'b00010, 1, 0, 0);
        idle("a9_s2", 5'b00100, 1, 0, 0);
        step("a9_clear", 1'b0, 1'b0, 5'b00000, 1'b0, 4'd0, 5'b00000, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            idle("a9_after", 5'b00000, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shiftregister_circular_left_stepper.md
Name: shiftregister_circular_left_stepper

Overview:
- WIDTH-bit circular shift register that rotates LEFT (toward the MSB); it is the opposite-direction counterpart of the team's circular right shift register.
- Parallel preset load, then a start/busy/done handshake that rotates left by a requested number of steps, one step per clock.
- Used by lab sequencer and LED-ring datapaths that need a known rotation count, not free-running rotation.

Parameters:
- WIDTH, 5, register width in bits (>= 2)
- AW, 4, width of the amount input; max request 2^AW-1 steps

Ports:
- clockpulse  input  1  clock; all state updates on the rising edge
- clear  input  1  synchronous, active-low reset, sampled on the rising edge of clockpulse
- preset_enable  input  1  load preset into the register (IDLE only)
- preset  input  WIDTH  parallel load value
- start  input  1  begin a rotation of `amount` steps (IDLE only)
- amount  input  AW  number of left-rotate steps, sampled with start
- signal_q  output  WIDTH  register contents
- signal_q_  output  WIDTH  bitwise complement of signal_q, always
- busy  output  1  high while rotating
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (clear==0 at an edge): signal_q=0, signal_q_=all ones, busy=0, done=0, remaining=0, state=IDLE. Reset overrides everything, including mid-rotation.
- One left-rotate step: q <= {q[WIDTH-2:0], q[WIDTH-1]}. The MSB wraps to bit 0.
- States: IDLE, ROTATE, DONE.
- IDLE, preset_enable=1: q <= preset at the edge; stay in IDLE. preset_enable has priority: start in the same cycle is dropped.
- IDLE, start=1, preset_enable=0, amount=N:
  - N>0: go to ROTATE; remaining <= N.
  - N==0: go directly to DONE; no rotation.
- ROTATE: busy=1. Each edge performs one step and decrements remaining. The edge with remaining==1 performs the final step and goes to DONE.
- DONE: done=1 and busy=0 for exactly one cycle; q holds the final value. Returns to IDLE unconditionally. start in DONE is ignored.
- Latency: start sampled at edge k with N>0 gives rotations at edges k+1..k+N and busy high in the cycles after edges k+1..k+N-1. At edge k+N the state becomes DONE, with done high until edge k+N+1.
- start and preset_enable are ignored while in ROTATE or DONE. amount is sampled only with an accepted start.
- N >= WIDTH wraps naturally: the final value equals a rotation by N mod WIDTH.
- busy and done are never high in the same cycle.

Optional Feature:
- Macro: REVOLUTION_FLAG_EN.
- Defined:
  - Adds output port revolution (1 bit) and a mod-WIDTH step counter.
  - The counter is cleared by reset and by an accepted preset load.
  - It increments on every rotate step.
  - revolution pulses high for one cycle after the step that wraps the counter from WIDTH-1 to 0, i.e. each full revolution since the last load.
  - revolution resets to 0.
- Undefined: no revolution port and no counter; all other behaviour is identical.

Test Plan:
- Reset, then preset_enable=1, preset=5'b10110 -> signal_q=10110 and signal_q_=01001 next cycle; busy=0, done=0.
- Load 00001; start with amount=3 -> busy high for 2 cycles, then done for 1 cycle; signal_q=01000; intermediate values 00010, 00100.
- Load 00001; amount=7 -> final 00100 (7 mod 5 = 2). With REVOLUTION_FLAG_EN, revolution pulses once, after the 5th step (q=00001).
- Load 10110; amount=0 -> done asserted the cycle after start; busy never high; q stays 10110.
- Load 10110; amount=4; pulse start and preset_enable=1 with preset=11111 while busy -> both ignored; final 01011.
- Rotation in progress (amount=9), clear=0 for one edge after 2 steps -> signal_q=00000, busy=0, done=0 next cycle; no done pulse afterwards.
